tx_gearbox_66b_n: RTL and testbench
===================================

TX_GEARBOX_66B_N -- requirements
Module: tx_gearbox_66b_n

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath width; legal values 32 and 64 only.
REQ-002 The block SHALL have parameter BIT_REV, default 0, meaning 0 = first-transmitted bit at data_o MSB, 1 = first-transmitted bit at data_o LSB.
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock, TX user clock.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port data_i, input, DATA_W bits: block payload, first-transmitted bit at MSB.
REQ-006 The block SHALL have port head_i, input, 2 bits: sync header, head_i[1] transmitted first; sampled only on header slots.
REQ-007 The block SHALL have port valid_i, input, 1 bit: upstream word present.
REQ-008 The block SHALL have port ready_o, output, 1 bit: the slot accepts a word this cycle.
REQ-009 The block SHALL have port data_o, output, DATA_W bits: line word, continuous every cycle.
REQ-010 The block SHALL have port seq_o, output, 7 bits: current slot counter, for GT external-sequence monitoring.
REQ-011 The block SHALL have port clear_i, input, 1 bit: clears underflow_o.
REQ-012 The block SHALL have port underflow_o, output, 1 bit: sticky flag, a ready slot passed with valid_i=0.

Function
REQ-013 Period SHALL be P = 2112/DATA_W cycles: 66 for DATA_W=32, 33 for DATA_W=64. seq_o counts 0..P-1, wraps to 0, and advances every cycle unconditionally.
REQ-014 ready_o SHALL be 1 for seq_o < P-2 (DATA_W=32) or seq_o < P-1 (DATA_W=64), else 0. This gives 64 or 32 accepted words per period.
REQ-015 A word SHALL be accepted when ready_o=1 and valid_i=1. valid_i while ready_o=0 is ignored and is not an error.
REQ-016 Header slots: for DATA_W=32, accepted-slot index k even; for DATA_W=64, every accepted slot. A header slot contributes {head_i, data_i} (DATA_W+2 bits). Other slots contribute data_i (DATA_W bits).
REQ-017 Contributed bits SHALL be appended to an internal bit queue in transmit order. Each cycle the oldest DATA_W bits are emitted on data_o. The output stream is the exact concatenation: no gap, duplication or reordering.
REQ-018 Queue occupancy after each period SHALL return to its start value, so there is no drift. Occupancy never exceeds 2*DATA_W+2 bits.
REQ-019 Latency: the first bit contributed at seq_o=0 of any period SHALL appear at the data_o transmit-first position exactly 2 cycles after acceptance.
REQ-020 Underflow: on a ready slot with valid_i=0, the block SHALL substitute all-zero data, and head 2'b00 on header slots (an invalid header, so the far end detects it). underflow_o SHALL be set the next cycle.
REQ-021 underflow_o SHALL stay set until clear_i=1. If clear_i and a new underflow occur in the same cycle, set wins.
REQ-022 BIT_REV=1 SHALL bit-reverse data_o only. Queue and input ordering are unchanged.

Reset
REQ-023 While rst_n_i=0: seq_o=0, ready_o=0, data_o=0, underflow_o=0, queue cleared. This is asynchronous and holds mid-period.
REQ-024 In the first cycle after rst_n_i rises, seq_o SHALL be 0 and ready_o SHALL be 1. The first 2 data_o words are zero.

Structure
REQ-025 A shared package SHALL hold: the period constants P32=66 and P64=33, the header constants HDR_DATA=2'b01, HDR_CTRL=2'b10 and HDR_BAD=2'b00, and a width-legality check function.
REQ-026 The block SHALL use one sub-module, gearbox_66b_align, a registered barrel placer that positions the contributed chunk at the queue write offset. The top holds the counter, the handshake, the queue and the flags.
REQ-027 An illegal DATA_W SHALL fail at elaboration.

Verification
REQ-028 DATA_W=32 with valid_i held 1 and 32 blocks of head 2'b01 plus an incrementing data pattern: output SHALL match the golden serialised stream bit-exact over 66 cycles, ready_o=0 at seq_o 64 and 65, and underflow_o=0.
REQ-029 DATA_W=64 with 3 periods of mixed heads 2'b01/2'b10: output SHALL be bit-exact, ready_o=0 only at seq_o=32, and latency SHALL be 2 cycles at each period start.
REQ-030 Drop valid_i at slot k=10 (a header slot, DATA_W=32): that block SHALL be emitted as 2'b00 followed by 32'h0, underflow_o SHALL be 1 from the next cycle, clear_i SHALL drop it, and the following blocks SHALL be unaffected.
REQ-031 Assert rst_n_i=0 at seq_o=37, release, and restart: outputs SHALL be zero during reset, seq_o SHALL be 0 after release, and the stream SHALL be bit-exact from the new period.
REQ-032 BIT_REV=1 with the stimulus of REQ-028: each data_o word SHALL equal the bit-reversed golden word.
REQ-033 clear_i and an underflow in the same cycle: underflow_o SHALL remain 1.

Source files
------------

// File: rtl/tx_gearbox_66b_n_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tx_gearbox_66b_n_pkg : shared constants for the 64b/66b TX gearbox
// Rev 1.0
// ------------------------------------------------------------------
package tx_gearbox_66b_n_pkg;

   localparam int P32 = 66;
   localparam int P64 = 33;

   typedef logic [1:0] hdr_t;

   localparam hdr_t HDR_DATA = 2'b01;
   localparam hdr_t HDR_CTRL = 2'b10;
   localparam hdr_t HDR_BAD  = 2'b00;

   function automatic bit width_ok(input int w);
      return (w == 32) || (w == 64);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_gearbox_66b_n_align.sv
`default_nettype none
// ------------------------------------------------------------------
// gearbox_66b_align : registered barrel placer, drops an MSB-first chunk
// at the queue write offset.  Rev 1.0
// ------------------------------------------------------------------
module gearbox_66b_align
   import tx_gearbox_66b_n_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int WORK_W = 3 * DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DATA_W+1:0] chunk_i,
   input  logic [7:0]        off_i,
   output logic [WORK_W-1:0] placed_o
);

   logic [WORK_W-1:0] w_wide;

   assign w_wide = {chunk_i, {(WORK_W - DATA_W - 2){1'b0}}};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         placed_o <= '0;
      end else begin
         placed_o <= w_wide >> off_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tx_gearbox_66b_n.sv
`default_nettype none
// ------------------------------------------------------------------
// tx_gearbox_66b_n : 64b/66b TX gearbox, external-sequence style.
// Rev 1.0
// ------------------------------------------------------------------
module tx_gearbox_66b_n
   import tx_gearbox_66b_n_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int BIT_REV = 0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        head_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] data_o,
   output logic [6:0]        seq_o,
   input  logic              clear_i,
   output logic              underflow_o
);

   localparam int         PERIOD = (DATA_W == 32) ? P32 : P64;
   localparam int         WORK_W = 3 * DATA_W;
   localparam logic [6:0] C_LAST = 7'(PERIOD - 1);
   localparam logic [6:0] C_NRDY = 7'((DATA_W == 32) ? PERIOD - 2 : PERIOD - 1);
   localparam logic [7:0] C_W    = 8'(DATA_W);

   generate
      if (!width_ok(DATA_W)) begin : g_bad_width
         $error("tx_gearbox_66b_n: DATA_W must be 32 or 64");
      end
   endgenerate

   logic [6:0]          r_seq;
   logic [7:0]          r_fill;   // queue occupancy when the chunk taken now is merged
   logic [2*DATA_W-1:0] r_q;
   logic [DATA_W-1:0]   r_word;
   logic                r_under;
   logic                w_ready;
   logic                w_hdr_slot;
   logic [DATA_W+1:0]   w_chunk;
   logic [7:0]          w_len;
   logic [WORK_W-1:0]   w_placed;
   logic [WORK_W-1:0]   w_comb;

   assign w_ready    = rst_n_i && (r_seq < C_NRDY);
   assign w_hdr_slot = (DATA_W == 64) || !r_seq[0];

   always_comb begin
      w_chunk = '0;
      w_len   = '0;
      if (w_ready) begin
         if (w_hdr_slot) begin
            w_chunk = valid_i ? {head_i, data_i} : {HDR_BAD, {DATA_W{1'b0}}};
            w_len   = C_W + 8'd2;
         end else begin
            w_chunk = valid_i ? {data_i, 2'b00} : '0;
            w_len   = C_W;
         end
      end
   end

   gearbox_66b_align #(
      .DATA_W (DATA_W),
      .WORK_W (WORK_W)
   ) u_align (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .chunk_i  (w_chunk),
      .off_i    (r_fill),
      .placed_o (w_placed)
   );

   // Queue is MSB-aligned: the top DATA_W bits leave, the rest shift up.
   assign w_comb = {r_q, {DATA_W{1'b0}}} | w_placed;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_seq   <= '0;
         r_fill  <= '0;
         r_q     <= '0;
         r_word  <= '0;
         r_under <= 1'b0;
      end else begin
         r_seq  <= (r_seq == C_LAST) ? 7'd0 : r_seq + 7'd1;
         r_fill <= r_fill + w_len - C_W;
         r_q    <= w_comb[2*DATA_W-1:0];
         r_word <= w_comb[WORK_W-1 -: DATA_W];
         if (w_ready && !valid_i) begin
            r_under <= 1'b1;
         end else if (clear_i) begin
            r_under <= 1'b0;
         end
      end
   end

   assign ready_o     = w_ready;
   assign seq_o       = r_seq;
   assign underflow_o = r_under;

   generate
      if (BIT_REV != 0) begin : g_rev
         for (genvar i = 0; i < DATA_W; i++) begin : g_bit
            assign data_o[i] = r_word[DATA_W-1-i];
         end
      end else begin : g_fwd
         assign data_o = r_word;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tx_gearbox_66b_n.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_tx_gearbox_66b_n : bit-queue reference model bench for the gearbox.
// Rev 1.0
// ------------------------------------------------------------------
module tb_tx_gearbox_66b_n;
   import tx_gearbox_66b_n_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst32_n = 1'b1, valid32 = 1'b0, clear32 = 1'b0;
   logic [1:0]  head32  = 2'b00;
   logic [31:0] data32  = '0;
   logic        ready32, ready32r, under32, under32r;
   logic [31:0] dout32, dout32r;
   logic [6:0]  seq32, seq32r;

   logic        rst64_n = 1'b1, valid64 = 1'b0, clear64 = 1'b0;
   logic [1:0]  head64  = 2'b00;
   logic [63:0] data64  = '0;
   logic        ready64, under64;
   logic [63:0] dout64;
   logic [6:0]  seq64;

   tx_gearbox_66b_n #(.DATA_W(32), .BIT_REV(0)) u_dut32 (
      .clk_i(clk), .rst_n_i(rst32_n), .data_i(data32), .head_i(head32), .valid_i(valid32),
      .ready_o(ready32), .data_o(dout32), .seq_o(seq32), .clear_i(clear32), .underflow_o(under32));

   tx_gearbox_66b_n #(.DATA_W(32), .BIT_REV(1)) u_dut32r (
      .clk_i(clk), .rst_n_i(rst32_n), .data_i(data32), .head_i(head32), .valid_i(valid32),
      .ready_o(ready32r), .data_o(dout32r), .seq_o(seq32r), .clear_i(clear32), .underflow_o(under32r));

   tx_gearbox_66b_n #(.DATA_W(64), .BIT_REV(0)) u_dut64 (
      .clk_i(clk), .rst_n_i(rst64_n), .data_i(data64), .head_i(head64), .valid_i(valid64),
      .ready_o(ready64), .data_o(dout64), .seq_o(seq64), .clear_i(clear64), .underflow_o(under64));

   int n_pass  = 0;
   int n_total = 0;

   // Reference: transmitted bits in order; output is two zero words then the stream.
   bit q32[$];
   int m32_seq = 0, m32_k = 0, m32_cyc = 0;
   bit m32_und = 1'b0;
   bit q64[$];
   int m64_seq = 0, m64_cyc = 0;
   bit m64_und = 1'b0;

   task automatic exp32(output logic [40:0] v, output logic [31:0] rv);
      logic [31:0] w;
      w = '0;
      if (m32_cyc >= 2)
         for (int i = 0; i < 32; i++) w[31-i] = (q32.size() > 0) ? q32.pop_front() : 1'b0;
      for (int i = 0; i < 32; i++) rv[i] = w[31-i];
      v = {w, 7'(m32_seq), (m32_seq < 64) ? 1'b1 : 1'b0, m32_und};
   endtask

   task automatic drv32(input logic v, input logic [1:0] h, input logic [31:0] d, input logic clr);
      logic       rdy;
      logic [1:0] hh;
      logic [31:0] dd;
      rdy = (m32_seq < 64);
      valid32 = v; head32 = h; data32 = d; clear32 = clr;
      hh = v ? h : HDR_BAD;
      dd = v ? d : 32'h0;
      if (rdy) begin
         if (m32_k % 2 == 0) begin
            q32.push_back(hh[1]);
            q32.push_back(hh[0]);
         end
         for (int i = 31; i >= 0; i--) q32.push_back(dd[i]);
         m32_k++;
      end
      m32_und = (rdy && !v) ? 1'b1 : (clr ? 1'b0 : m32_und);
      m32_seq = (m32_seq + 1) % 66;
      if (m32_seq == 0) m32_k = 0;
      m32_cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic exp64(output logic [72:0] v);
      logic [63:0] w;
      w = '0;
      if (m64_cyc >= 2)
         for (int i = 0; i < 64; i++) w[63-i] = (q64.size() > 0) ? q64.pop_front() : 1'b0;
      v = {w, 7'(m64_seq), (m64_seq < 32) ? 1'b1 : 1'b0, m64_und};
   endtask

   task automatic drv64(input logic v, input logic [1:0] h, input logic [63:0] d, input logic clr);
      logic       rdy;
      logic [1:0] hh;
      logic [63:0] dd;
      rdy = (m64_seq < 32);
      valid64 = v; head64 = h; data64 = d; clear64 = clr;
      hh = v ? h : HDR_BAD;
      dd = v ? d : 64'h0;
      if (rdy) begin
         q64.push_back(hh[1]);
         q64.push_back(hh[0]);
         for (int i = 63; i >= 0; i--) q64.push_back(dd[i]);
      end
      m64_und = (rdy && !v) ? 1'b1 : (clr ? 1'b0 : m64_und);
      m64_seq = (m64_seq + 1) % 33;
      m64_cyc++;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] rand_head();
      return ($urandom_range(0, 1) != 0) ? HDR_DATA : HDR_CTRL;
   endfunction

   task automatic test_reset32();
      rst32_n = 1'b0; valid32 = 1'b0; clear32 = 1'b0; head32 = 2'b00; data32 = '0;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_total++;
         if ({dout32, seq32, ready32, under32} !== 41'h0)
            $display("FAIL reset32 c=%0d got %h exp 0", c, {dout32, seq32, ready32, under32});
         else n_pass++;
         n_total++;
         if ({dout32r, seq32r, ready32r, under32r} !== 41'h0)
            $display("FAIL reset32r c=%0d got %h exp 0", c, {dout32r, seq32r, ready32r, under32r});
         else n_pass++;
         @(posedge clk);
         #1;
      end
      rst32_n = 1'b1;
      q32.delete();
      m32_seq = 0; m32_k = 0; m32_cyc = 0; m32_und = 1'b0;
      #1;
      n_total++;
      if ({seq32, ready32} !== {7'd0, 1'b1})
         $display("FAIL release32 got seq=%0d rdy=%b exp seq=0 rdy=1", seq32, ready32);
      else n_pass++;
   endtask

   task automatic test_period32();
      logic [40:0] v;
      logic [31:0] rv;
      for (int c = 0; c < 66; c++) begin
         exp32(v, rv);
         n_total++;
         if ({dout32, seq32, ready32, under32} !== v)
            $display("FAIL period32 c=%0d got %h exp %h", c, {dout32, seq32, ready32, under32}, v);
         else n_pass++;
         n_total++;
         if ({dout32r, seq32r, ready32r, under32r} !== {rv, v[8:0]})
            $display("FAIL bitrev32 c=%0d got %h exp %h", c, {dout32r, seq32r, ready32r, under32r}, {rv, v[8:0]});
         else n_pass++;
         drv32(1'b1, HDR_DATA, 32'(c), 1'b0);
      end
   endtask

   task automatic test_random32();
      logic [40:0] v;
      logic [31:0] rv;
      for (int c = 0; c < 198; c++) begin
         exp32(v, rv);
         n_total++;
         if ({dout32, seq32, ready32, under32} !== v)
            $display("FAIL random32 c=%0d got %h exp %h", c, {dout32, seq32, ready32, under32}, v);
         else n_pass++;
         n_total++;
         if ({dout32r, seq32r, ready32r, under32r} !== {rv, v[8:0]})
            $display("FAIL random32r c=%0d got %h exp %h", c, {dout32r, seq32r, ready32r, under32r}, {rv, v[8:0]});
         else n_pass++;
         drv32(1'b1, rand_head(), 32'($urandom), ($urandom_range(0, 7) == 0));
      end
   endtask

   task automatic test_underflow32();
      logic [40:0] v;
      logic [31:0] rv;
      logic        drop, clr;
      for (int c = 0; c < 132; c++) begin
         drop = (c == 10) || (c == 71);
         clr  = (c == 20) || (c == 71) || (c == 90);
         if (c == 11 || c == 72) begin
            n_total++;
            if (under32 !== 1'b1) $display("FAIL under_set c=%0d got %b exp 1", c, under32);
            else n_pass++;
         end
         if (c == 21 || c == 91) begin
            n_total++;
            if (under32 !== 1'b0) $display("FAIL under_clear c=%0d got %b exp 0", c, under32);
            else n_pass++;
         end
         exp32(v, rv);
         n_total++;
         if ({dout32, seq32, ready32, under32} !== v)
            $display("FAIL under32 c=%0d got %h exp %h", c, {dout32, seq32, ready32, under32}, v);
         else n_pass++;
         n_total++;
         if ({dout32r, seq32r, ready32r, under32r} !== {rv, v[8:0]})
            $display("FAIL under32r c=%0d got %h exp %h", c, {dout32r, seq32r, ready32r, under32r}, {rv, v[8:0]});
         else n_pass++;
         drv32(!drop, rand_head(), 32'($urandom), clr);
      end
   endtask

   task automatic test_reset_mid32();
      logic [40:0] v;
      logic [31:0] rv;
      for (int c = 0; c < 66 && m32_seq != 37; c++) begin
         exp32(v, rv);
         n_total++;
         if ({dout32, seq32, ready32, under32} !== v)
            $display("FAIL pre_rst32 c=%0d got %h exp %h", c, {dout32, seq32, ready32, under32}, v);
         else n_pass++;
         drv32(1'b1, rand_head(), 32'($urandom), 1'b0);
      end
      n_total++;
      if (seq32 !== 7'd37) $display("FAIL mid_seq got %0d exp 37", seq32);
      else n_pass++;
      test_reset32();
      for (int c = 0; c < 134; c++) begin
         exp32(v, rv);
         n_total++;
         if ({dout32, seq32, ready32, under32} !== v)
            $display("FAIL post_rst32 c=%0d got %h exp %h", c, {dout32, seq32, ready32, under32}, v);
         else n_pass++;
         n_total++;
         if ({dout32r, seq32r, ready32r, under32r} !== {rv, v[8:0]})
            $display("FAIL post_rst32r c=%0d got %h exp %h", c, {dout32r, seq32r, ready32r, under32r}, {rv, v[8:0]});
         else n_pass++;
         drv32(1'b1, rand_head(), 32'($urandom), 1'b0);
      end
   endtask

   task automatic test_reset64();
      rst64_n = 1'b0; valid64 = 1'b0; clear64 = 1'b0; head64 = 2'b00; data64 = '0;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_total++;
         if ({dout64, seq64, ready64, under64} !== 73'h0)
            $display("FAIL reset64 c=%0d got %h exp 0", c, {dout64, seq64, ready64, under64});
         else n_pass++;
         @(posedge clk);
         #1;
      end
      rst64_n = 1'b1;
      q64.delete();
      m64_seq = 0; m64_cyc = 0; m64_und = 1'b0;
      #1;
      n_total++;
      if ({seq64, ready64} !== {7'd0, 1'b1})
         $display("FAIL release64 got seq=%0d rdy=%b exp seq=0 rdy=1", seq64, ready64);
      else n_pass++;
   endtask

   task automatic test_period64();
      logic [72:0] v;
      logic [1:0]  h, h0;
      logic [63:0] d, d0;
      h0 = '0;
      d0 = '0;
      for (int c = 0; c < 102; c++) begin
         if (m64_seq == 2 && m64_cyc >= 2) begin
            n_total++;
            if (dout64 !== {h0, d0[63:2]})
               $display("FAIL latency64 c=%0d got %h exp %h", c, dout64, {h0, d0[63:2]});
            else n_pass++;
         end
         exp64(v);
         n_total++;
         if ({dout64, seq64, ready64, under64} !== v)
            $display("FAIL period64 c=%0d got %h exp %h", c, {dout64, seq64, ready64, under64}, v);
         else n_pass++;
         h = rand_head();
         d = {32'($urandom), 32'($urandom)};
         if (m64_seq == 0) begin
            h0 = h;
            d0 = d;
         end
         drv64(1'b1, h, d, 1'b0);
      end
   endtask

   task automatic test_underflow64();
      logic [72:0] v;
      for (int c = 0; c < 68; c++) begin
         exp64(v);
         n_total++;
         if ({dout64, seq64, ready64, under64} !== v)
            $display("FAIL under64 c=%0d got %h exp %h", c, {dout64, seq64, ready64, under64}, v);
         else n_pass++;
         drv64(($urandom_range(0, 7) != 0), rand_head(), {32'($urandom), 32'($urandom)},
               ($urandom_range(0, 15) == 0));
      end
   endtask

   initial begin
      #1;
      test_reset32();
      test_period32();
      test_random32();
      test_underflow32();
      test_reset_mid32();
      test_reset64();
      test_period64();
      test_underflow64();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
